// File: rtl/mem_arb.sv
// Two-port memory arbiter: instruction fetch and load/store share one memory port.
// One access in flight at a time; fixed read latency LAT; alternating priority on contention.
module mem_arb #(
    parameter int unsigned LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [3:0]  ls_be,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_owner_q, last_owner_d;  // 0 = fetch, 1 = load/store
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        if_win, ls_win;

    // Pick a winner in IDLE; on contention the side that did not win last time goes.
    // Grants are suppressed while reset is asserted even though IDLE is forced.
    always_comb begin
        if_win = 1'b0;
        ls_win = 1'b0;
        if (state_q == StIdle && rst_n) begin
            if (if_req && ls_req) begin
                ls_win = ~last_owner_q;
                if_win = last_owner_q;
            end else begin
                if_win = if_req;
                ls_win = ls_req;
            end
        end
    end

    // Next-state logic, request capture and response steering.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        we_d         = we_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        if_gnt       = if_win;
        ls_gnt       = ls_win;
        if_rvalid    = 1'b0;
        ls_rvalid    = 1'b0;
        if_rdata     = '0;
        ls_rdata     = '0;
        mem_en       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (if_win || ls_win) begin
                    owner_d      = ls_win;
                    last_owner_d = ls_win;
                    we_d         = ls_win & ls_we;
                    be_d         = ls_win ? ls_be : 4'hF;
                    addr_d       = ls_win ? ls_addr : if_addr;
                    wdata_d      = ls_win ? ls_wdata : '0;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                mem_en  = 1'b1;
                cnt_d   = 4'(LAT - 1);
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (owner_q) begin
                        ls_rvalid = 1'b1;
                        ls_rdata  = we_q ? '0 : mem_rdata;
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Memory strobe only in ISSUE; write enable is qualified by the strobe.
    assign mem_we    = mem_en & we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // State register; reset drops any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_owner_q <= 1'b0;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter LAT, default 2, SHALL set memory read latency in cycles after mem_en; legal range 1..15.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 if_req  input  1  instruction-fetch request, held until if_gnt.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_gnt  output  1  fetch request accepted this cycle.
REQ-007 if_rvalid  output  1  fetch data valid, one-cycle pulse.
REQ-008 if_rdata  output  32  fetch data.
REQ-009 ls_req  input  1  load/store request, held until ls_gnt.
REQ-010 ls_we  input  1  1 = store, 0 = load.
REQ-011 ls_be  input  4  byte enables.
REQ-012 ls_addr  input  32  load/store byte address.
REQ-013 ls_wdata  input  32  store data.
REQ-014 ls_gnt  output  1  load/store request accepted this cycle.
REQ-015 ls_rvalid  output  1  load data valid / store complete, one-cycle pulse.
REQ-016 ls_rdata  output  32  load data; 0 for stores.
REQ-017 mem_en  output  1  memory access strobe.
REQ-018 mem_we  output  1  memory write enable.
REQ-019 mem_be  output  4  memory byte enables.
REQ-020 mem_addr  output  32  memory address.
REQ-021 mem_wdata  output  32  memory write data.
REQ-022 mem_rdata  input  32  memory read data, valid LAT cycles after mem_en.

Function
REQ-023 FSM states SHALL be IDLE, ISSUE, WAIT; 4-bit counter cnt; 1-bit last_owner (0 = fetch, 1 = load/store).
REQ-024 IDLE, neither req: stay IDLE, no gnt.
REQ-025 IDLE, single req: that requester wins; IDLE, both req: winner = requester not equal to last_owner.
REQ-026 Grant SHALL be combinational in IDLE only (same cycle as winning req); loser sees gnt=0 and holds req.
REQ-027 On grant SHALL register address, we, be, wdata (fetch: we=0, be=4'hF, wdata=0), owner; last_owner <= winner; next state ISSUE.
REQ-028 ISSUE SHALL last one cycle: mem_en=1, mem_* driven from registered fields; cnt <= LAT-1; next state WAIT.
REQ-029 WAIT with cnt != 0: cnt decrements each cycle; no gnt, no rvalid.
REQ-030 WAIT with cnt == 0: owner's rvalid = 1 for one cycle; rdata = mem_rdata for reads, 0 for stores; next state IDLE.
REQ-031 Latency: req granted in cycle T -> mem_en in T+1 -> rvalid in T+1+LAT; next grant earliest T+2+LAT.
REQ-032 Non-owner rvalid SHALL be 0; non-owner rdata SHALL be 0.
REQ-033 Requests in ISSUE/WAIT SHALL be ignored (gnt=0); requester keeps req high.
REQ-034 mem_en SHALL be 0 outside ISSUE; mem_we SHALL equal registered we only when mem_en=1, else 0.
REQ-035 Addresses SHALL pass through unmodified; no alignment check.

Reset
REQ-036 rst_n low, any state (including mid-ISSUE/WAIT): state <= IDLE, cnt <= 0, last_owner <= 0, registered fields <= 0; in-flight access dropped, no rvalid issued.
REQ-037 During and after reset: all gnt, rvalid, mem_en, mem_we = 0; all data/address outputs = 0 until first grant.
REQ-038 After reset, first contention SHALL go to load/store (last_owner = 0).

Verification
REQ-039 LAT=2; if_req, if_addr=0x100 at T, mem returns 0xDEADBEEF -> if_gnt at T, mem_en/mem_addr=0x100/mem_be=F at T+1, if_rvalid with 0xDEADBEEF at T+3.
REQ-040 Both req held continuously after reset -> grants alternate ls, if, ls, if at T, T+4, T+8, T+12 (LAT=2).
REQ-041 Store ls_we=1, be=4'b0011, addr=0x20, wdata=0x1234 -> mem_we=1 with those values for exactly one cycle, ls_rvalid with ls_rdata=0 LAT cycles later.
REQ-042 rst_n asserted during WAIT -> no rvalid pulse; after release, pending if_req granted in first IDLE cycle.
REQ-043 LAT=1 and LAT=15 -> rvalid at T+2 and T+16 respectively; no grant accepted between.
